// File: rtl/decoder_pkg.sv
// Shared encodings for the sequenced instruction decoder: ALU op codes,
// one-hot phase states and bit indices, branch kinds and opcode bytes.
package decoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_CMP = 4'd2,  OP_AND = 4'd3,
    OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_NEG = 4'd6,  OP_NOT = 4'd7,
    OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_LD  = 4'd11,
    OP_ST  = 4'd12, OP_MOV = 4'd13, OP_LIL = 4'd14, OP_HLT = 4'd15
  } op_e;

  typedef enum logic [4:0] {
    PH_F = 5'b00001,
    PH_R = 5'b00010,
    PH_X = 5'b00100,
    PH_M = 5'b01000,
    PH_W = 5'b10000
  } phase_e;

  localparam int F = 0;
  localparam int R = 1;
  localparam int X = 2;
  localparam int M = 3;
  localparam int W = 4;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_B    = 2'b10;
  localparam logic [1:0] BR_BCC  = 2'b01;

  localparam logic [7:0] OPB_LD  = 8'h8B;
  localparam logic [7:0] OPB_ST  = 8'h89;
  localparam logic [7:0] OPB_LIL = 8'h66;
  localparam logic [7:0] OPB_ADD = 8'h01;
  localparam logic [7:0] OPB_SUB = 8'h29;
  localparam logic [7:0] OPB_CMP = 8'h39;
  localparam logic [7:0] OPB_AND = 8'h21;
  localparam logic [7:0] OPB_OR  = 8'h09;
  localparam logic [7:0] OPB_XOR = 8'h31;
  localparam logic [7:0] OPB_IMM = 8'h83;
  localparam logic [7:0] OPB_UNA = 8'hF7;
  localparam logic [7:0] OPB_SHF = 8'hC1;
  localparam logic [7:0] OPB_JMP = 8'h90;
  localparam logic [7:0] OPB_HLT = 8'hF4;

endpackage

// File: rtl/decoder_seq_phase_ring.sv
// One-hot f->r->x->m->w phase sequencer. Holds on stall, on freeze
// (halted/illegal) and in f while no instruction is waiting. 'first'
// marks the single cycle right after a phase is entered, so stalls never
// re-trigger downstream strobes.
module phase_ring
  import decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       freeze,
  input  logic       wait_f,
  output logic [4:0] phase,
  output logic [4:0] first,
  output logic       leave_f
);

  phase_e state;
  logic   adv;

  assign adv     = !stall && !freeze && !((state == PH_F) && wait_f);
  assign leave_f = adv && (state == PH_F);
  assign phase   = state;

  // Step the ring when allowed and flag the newly entered phase for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PH_F;
      first <= '0;
    end else if (adv) begin
      case (state)
        PH_F:    begin state <= PH_R; first <= PH_R; end
        PH_R:    begin state <= PH_X; first <= PH_X; end
        PH_X:    begin state <= PH_M; first <= PH_M; end
        PH_M:    begin state <= PH_W; first <= PH_W; end
        default: begin state <= PH_F; first <= PH_F; end
      endcase
    end else begin
      first <= '0;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Sequenced instruction decoder: decodes ir once on leaving f, holds the
// fields until the next decode, and issues one-shot memory/regfile/branch
// strobes on the first cycle of m and w. HLT and illegal encodings freeze
// the ring at r until reset.
// Optional: define DECODER_SEQ_IMM_SIGN_EXT_EN to sign-extend the
// immediate (and jump displacement) instead of zero-extending it.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IM_W   = 8,
  parameter int RA_W   = 3,
  parameter int BR_OFS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ir,
  input  logic              ir_valid,
  input  logic              stall,
  output logic [4:0]        phase,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] im,
  output logic              use_im,
  output logic [1:0]        br,
  output logic [RA_W-1:0]   ra1,
  output logic [RA_W-1:0]   ra2,
  output logic              load_en,
  output logic              wren_mem,
  output logic              wren_reg,
  output logic              cr_taken,
  output logic              illegal,
  output logic              halted
);

  logic [4:0]        first;
  logic              decode;
  logic              mem_q, reg_q, cr_q;
  logic [DATA_W-1:0] ext_im;
  logic [4:0]        sub;
  logic              unused_bits;

  op_e               d_op;
  logic [DATA_W-1:0] d_im;
  logic [1:0]        d_br;
  logic              d_use_im, d_load, d_mem, d_reg, d_cr, d_ill, d_hlt, d_jmp;

  phase_ring u_ring (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .freeze  (halted | illegal),
    .wait_f  (!ir_valid),
    .phase   (phase),
    .first   (first),
    .leave_f (decode)
  );

`ifdef DECODER_SEQ_IMM_SIGN_EXT_EN
  assign ext_im = {{(DATA_W-IM_W){ir[8+IM_W-1]}}, ir[8+IM_W-1:8]};
`else
  assign ext_im = {{(DATA_W-IM_W){1'b0}}, ir[8+IM_W-1:8]};
`endif

  assign sub         = ir[23:19];
  assign unused_bits = ^{ir[7:0], ir[15:8], first[2:0]};

  // Combinational decode of the opcode byte and its sub-fields
  always_comb begin
    d_op     = OP_ADD;
    d_br     = BR_NONE;
    d_use_im = 1'b0;
    d_load   = 1'b0;
    d_mem    = 1'b0;
    d_reg    = 1'b0;
    d_cr     = 1'b0;
    d_ill    = 1'b0;
    d_hlt    = 1'b0;
    d_jmp    = 1'b0;
    case (ir[31:24])
      OPB_LD:  begin d_op = OP_LD; d_load = 1'b1; d_reg = 1'b1; end
      OPB_ST:  begin
        if (ir[23:22] == 2'b11) begin d_op = OP_MOV; d_reg = 1'b1; end
        else                    begin d_op = OP_ST;  d_mem = 1'b1; end
      end
      OPB_LIL: begin d_op = OP_LIL; d_use_im = 1'b1; d_reg = 1'b1; end
      OPB_ADD: begin d_op = OP_ADD; d_reg = 1'b1; end
      OPB_SUB: begin d_op = OP_SUB; d_reg = 1'b1; end
      OPB_CMP: begin d_op = OP_CMP; d_reg = 1'b1; end
      OPB_AND: begin d_op = OP_AND; d_reg = 1'b1; end
      OPB_OR:  begin d_op = OP_OR;  d_reg = 1'b1; end
      OPB_XOR: begin d_op = OP_XOR; d_reg = 1'b1; end
      OPB_IMM: begin
        d_use_im = 1'b1;
        d_reg    = 1'b1;
        case (sub)
          5'b11000: d_op = OP_ADD;
          5'b11101: d_op = OP_SUB;
          5'b11111: d_op = OP_CMP;
          5'b11100: d_op = OP_AND;
          5'b11001: d_op = OP_OR;
          5'b11110: d_op = OP_XOR;
          default:  d_ill = 1'b1;
        endcase
      end
      OPB_UNA: begin
        d_reg = 1'b1;
        case (sub)
          5'b11011: d_op = OP_NEG;
          5'b11010: d_op = OP_NOT;
          default:  d_ill = 1'b1;
        endcase
      end
      OPB_SHF: begin
        d_use_im = 1'b1;
        d_reg    = 1'b1;
        case (sub)
          5'b11100: d_op = OP_SLL;
          5'b11101: d_op = OP_SRL;
          5'b11111: d_op = OP_SRA;
          default:  d_ill = 1'b1;
        endcase
      end
      OPB_JMP: begin
        d_use_im = 1'b1;
        d_cr     = 1'b1;
        d_jmp    = 1'b1;
        case (ir[23:20])
          4'b1110: d_br  = BR_B;
          4'b0111: d_br  = BR_BCC;
          default: d_ill = 1'b1;
        endcase
      end
      OPB_HLT: begin d_op = OP_HLT; d_hlt = 1'b1; end
      default: d_ill = 1'b1;
    endcase
    // An illegal encoding leaves every field inert so nothing downstream acts on it
    if (d_ill) begin
      d_op     = OP_ADD;
      d_br     = BR_NONE;
      d_use_im = 1'b0;
      d_load   = 1'b0;
      d_mem    = 1'b0;
      d_reg    = 1'b0;
      d_cr     = 1'b0;
      d_jmp    = 1'b0;
    end
    if (!d_use_im)  d_im = '0;
    else if (d_jmp) d_im = ext_im + DATA_W'(BR_OFS);
    else            d_im = ext_im;
  end

  // Capture decoded fields and sticky flags on the edge that leaves f
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= OP_ADD;
      im      <= '0;
      use_im  <= 1'b0;
      br      <= BR_NONE;
      ra1     <= '0;
      ra2     <= '0;
      load_en <= 1'b0;
      mem_q   <= 1'b0;
      reg_q   <= 1'b0;
      cr_q    <= 1'b0;
      illegal <= 1'b0;
      halted  <= 1'b0;
    end else if (decode) begin
      op      <= d_op;
      im      <= d_im;
      use_im  <= d_use_im;
      br      <= d_br;
      ra1     <= RA_W'(ir[21:19]);
      ra2     <= RA_W'(ir[18:16]);
      load_en <= d_load;
      mem_q   <= d_mem;
      reg_q   <= d_reg;
      cr_q    <= d_cr;
      illegal <= d_ill;
      halted  <= d_hlt;
    end
  end

  assign wren_mem = first[M] & mem_q;
  assign wren_reg = first[W] & reg_q;
  assign cr_taken = first[W] & cr_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: the driver advances a phase-index model
// and pushes expected decodes; a negedge monitor pops them when the DUT
// enters r and checks the per-instruction strobes.
module tb_decoder_seq;

  localparam int DATA_W = 32;
  localparam int IM_W   = 8;
  localparam int RA_W   = 3;
  localparam int BR_OFS = 3;

  logic              clk = 1'b0;
  logic              rst, ir_valid, stall;
  logic [31:0]       ir;
  logic [4:0]        phase;
  logic [3:0]        op;
  logic [DATA_W-1:0] im;
  logic              use_im;
  logic [1:0]        br;
  logic [RA_W-1:0]   ra1, ra2;
  logic              load_en, wren_mem, wren_reg, cr_taken, illegal, halted;

  decoder_seq #(.DATA_W(DATA_W), .IM_W(IM_W), .RA_W(RA_W), .BR_OFS(BR_OFS)) dut (
    .clk(clk), .rst(rst), .ir(ir), .ir_valid(ir_valid), .stall(stall),
    .phase(phase), .op(op), .im(im), .use_im(use_im), .br(br),
    .ra1(ra1), .ra2(ra2), .load_en(load_en), .wren_mem(wren_mem),
    .wren_reg(wren_reg), .cr_taken(cr_taken), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] im;
    logic        use_im;
    logic [1:0]  br;
    logic [2:0]  ra1, ra2;
    logic        load, mem, wreg, cr, ill, hlt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   ph_m = 0;
  bit   ill_m = 0, hlt_m = 0;

  int rr_op[logic [7:0]];
  int imm_op[logic [4:0]];
  int una_op[logic [4:0]];
  int shf_op[logic [4:0]];
  logic [1:0] jmp_br[logic [3:0]];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference decode from the instruction-set rules (tables + arithmetic)
  function automatic exp_t ref_decode(input logic [31:0] v);
    exp_t       e;
    logic [7:0] opc;
    logic [4:0] sf;
    logic [3:0] bsel;
    longint     val;
    int         raw;
    bit         jmp;
    e = '0; jmp = 0;
    opc = v[31:24]; sf = v[23:19]; bsel = v[23:20];
    e.ra1 = v[21:19]; e.ra2 = v[18:16];
    if (rr_op.exists(opc)) begin e.op = 4'(rr_op[opc]); e.wreg = 1; end
    else if (opc == 8'h8B) begin e.op = 11; e.load = 1; e.wreg = 1; end
    else if (opc == 8'h89) begin
      if (v[23:22] == 2'b11) begin e.op = 13; e.wreg = 1; end
      else begin e.op = 12; e.mem = 1; end
    end
    else if (opc == 8'h66) begin e.op = 14; e.use_im = 1; e.wreg = 1; end
    else if (opc == 8'h83) begin
      e.use_im = 1; e.wreg = 1;
      if (imm_op.exists(sf)) e.op = 4'(imm_op[sf]); else e.ill = 1;
    end
    else if (opc == 8'hF7) begin
      e.wreg = 1;
      if (una_op.exists(sf)) e.op = 4'(una_op[sf]); else e.ill = 1;
    end
    else if (opc == 8'hC1) begin
      e.use_im = 1; e.wreg = 1;
      if (shf_op.exists(sf)) e.op = 4'(shf_op[sf]); else e.ill = 1;
    end
    else if (opc == 8'h90) begin
      e.use_im = 1; e.cr = 1; jmp = 1; e.op = 0;
      if (jmp_br.exists(bsel)) e.br = jmp_br[bsel]; else e.ill = 1;
    end
    else if (opc == 8'hF4) begin e.op = 15; e.hlt = 1; end
    else e.ill = 1;
    if (e.use_im) begin
      raw = int'(v[15:8]) % (1 << IM_W);
      val = longint'(raw);
`ifdef DECODER_SEQ_IMM_SIGN_EXT_EN
      if (raw >= (1 << (IM_W - 1))) val = longint'(raw) - longint'(1 << IM_W);
`endif
      if (jmp) val = val + BR_OFS;
      e.im = val[31:0];
    end
    if (e.ill) begin e.mem = 0; e.wreg = 0; e.cr = 0; end
    return e;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_phase", phase, 5'b00001);
    chk("rst_op", op, 0);
    chk("rst_im", im, 0);
    chk("rst_br", br, 0);
    chk("rst_ra1", ra1, 0);
    chk("rst_ra2", ra2, 0);
    chk("rst_flags", {use_im, load_en, wren_mem, wren_reg, cr_taken, illegal, halted}, 0);
  endtask

  // One clock: drive inputs, advance the phase model, then check at negedge
  task automatic step(input logic [31:0] v, input bit vld, input bit stl);
    logic [4:0] ep;
    ir = v; ir_valid = vld; stall = stl;
    @(posedge clk);
    if (!stl && !ill_m && !hlt_m && !(ph_m == 0 && !vld)) begin
      if (ph_m == 0) begin
        exp_t e;
        e = ref_decode(v);
        sb.push_back(e);
        ill_m = e.ill;
        hlt_m = e.hlt;
      end
      ph_m = (ph_m + 1) % 5;
    end
    @(negedge clk);
    ep = 5'b00001 << ph_m;
    chk("phase", phase, ep);
    chk("illegal", illegal, ill_m);
    chk("halted", halted, hlt_m);
  endtask

  task automatic run_instr(input logic [31:0] v, input int stall_ph, input int stall_len, input bit rnd);
    int guard = 0, stalled = 0;
    bit st;
    do begin
      st = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      step(v, 1'b1, st);
      guard++;
    end while (ph_m == 0 && guard < 10);
    while (ph_m != 0 && guard < 40) begin
      if (ill_m || hlt_m) begin
        repeat (3) step(v, 1'b1, 1'b0);
        break;
      end
      st = 1'b0;
      if (ph_m == stall_ph && stalled < stall_len) begin st = 1'b1; stalled++; end
      else if (rnd) st = ($urandom_range(0, 3) == 0);
      step(32'h0, 1'b0, st);
      guard++;
    end
    if (guard >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL run_bound: instr %h did not return to f within %0d cycles", v, guard);
    end
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge
  task automatic do_reset_check();
    ir_valid = 1'b0; stall = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    ph_m = 0; ill_m = 0; hlt_m = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0: v[31:24] = 8'h8B;   1: v[31:24] = 8'h89;   2: v[31:24] = 8'h66;
      3: v[31:24] = 8'h01;   4: v[31:24] = 8'h29;   5: v[31:24] = 8'h39;
      6: v[31:24] = 8'h21;   7: v[31:24] = 8'h09;   8: v[31:24] = 8'h31;
      9: v[31:24] = 8'h83;  10: v[31:24] = 8'hF7;  11: v[31:24] = 8'hC1;
      12: v[31:24] = 8'h90; 13: v[31:24] = 8'h90;  14: v[31:24] = 8'hF4;
      default: ;
    endcase
    if ($urandom_range(0, 7) != 0) begin
      case (v[31:24])
        8'h83: case ($urandom_range(0, 5))
                 0: v[23:19] = 5'b11000; 1: v[23:19] = 5'b11101; 2: v[23:19] = 5'b11111;
                 3: v[23:19] = 5'b11100; 4: v[23:19] = 5'b11001; default: v[23:19] = 5'b11110;
               endcase
        8'hF7: v[23:19] = $urandom_range(0, 1) ? 5'b11011 : 5'b11010;
        8'hC1: case ($urandom_range(0, 2))
                 0: v[23:19] = 5'b11100; 1: v[23:19] = 5'b11101; default: v[23:19] = 5'b11111;
               endcase
        8'h90: v[23:20] = $urandom_range(0, 1) ? 4'b1110 : 4'b0111;
        default: ;
      endcase
    end
    return v;
  endfunction

  // Monitor: pop on decode (entry into r), check strobes every cycle
  logic [4:0] prev_ph = 5'b00001;
  exp_t       cur;
  bit         active = 0;
  int         c_mem = 0, c_reg = 0, c_cr = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ph = 5'b00001;
      active  = 0;
    end else begin
      if (phase == 5'b00010 && prev_ph == 5'b00001) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_pop: decode seen with empty queue, op %0h", op);
          active = 0;
        end else begin
          cur = sb.pop_front();
          active = 1; c_mem = 0; c_reg = 0; c_cr = 0;
          if (!cur.ill) begin
            chk("op", op, cur.op);
            chk("im", im, cur.im);
            chk("use_im", use_im, cur.use_im);
            chk("br", br, cur.br);
            chk("ra1", ra1, cur.ra1);
            chk("ra2", ra2, cur.ra2);
            chk("load_en", load_en, cur.load);
          end
          chk("dec_illegal", illegal, cur.ill);
          chk("dec_halted", halted, cur.hlt);
        end
      end
      chk("wren_mem", wren_mem, active && cur.mem && phase == 5'b01000 && prev_ph != 5'b01000);
      chk("wren_reg", wren_reg, active && cur.wreg && phase == 5'b10000 && prev_ph != 5'b10000);
      chk("cr_taken", cr_taken, active && cur.cr && phase == 5'b10000 && prev_ph != 5'b10000);
      c_mem += int'(wren_mem); c_reg += int'(wren_reg); c_cr += int'(cr_taken);
      if (active && phase == 5'b00001 && prev_ph == 5'b10000) begin
        chk("mem_pulses", c_mem, cur.mem);
        chk("reg_pulses", c_reg, cur.wreg);
        chk("cr_pulses", c_cr, cur.cr);
        active = 0;
      end
      prev_ph = phase;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_op[8'h01] = 0; rr_op[8'h29] = 1; rr_op[8'h39] = 2;
    rr_op[8'h21] = 3; rr_op[8'h09] = 4; rr_op[8'h31] = 5;
    imm_op[5'b11000] = 0; imm_op[5'b11101] = 1; imm_op[5'b11111] = 2;
    imm_op[5'b11100] = 3; imm_op[5'b11001] = 4; imm_op[5'b11110] = 5;
    una_op[5'b11011] = 6; una_op[5'b11010] = 7;
    shf_op[5'b11100] = 8; shf_op[5'b11101] = 9; shf_op[5'b11111] = 10;
    jmp_br[4'b1110] = 2'b10; jmp_br[4'b0111] = 2'b01;

    rst = 1'b1; ir = '0; ir_valid = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // waiting in f: no instruction, then stall together with a valid one
    step(32'h0, 1'b0, 1'b0);
    step(32'h01C80000, 1'b1, 1'b1);
    step(32'h01C80000, 1'b1, 1'b1);

    run_instr(32'h01C80000, -1, 0, 0);
    chk("add_ra1", ra1, 1);
    run_instr(32'h89080000, -1, 0, 0);
    chk("st_op", op, 12);
    run_instr(32'h89C80000, -1, 0, 0);
    chk("mov_op", op, 13);
    run_instr(32'h90E0FE00, -1, 0, 0);
    chk("jmp_br", br, 2'b10);
`ifdef DECODER_SEQ_IMM_SIGN_EXT_EN
    chk("jmp_im", im, 32'h00000001);
`else
    chk("jmp_im", im, 32'h00000101);
`endif
    run_instr(32'h89080000, 3, 3, 0);
    run_instr(32'h83F80500, -1, 0, 0);
    chk("cmpi_op", op, 2);
    chk("cmpi_im", im, 5);
    run_instr(32'hF4000000, -1, 0, 0);
    chk("hlt_flag", halted, 1);
    do_reset_check();

    run_instr(32'hFF000000, -1, 0, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_phase", phase, 5'b00010);
    do_reset_check();

    // reset while in x: nothing from the interrupted instruction may fire
    step(32'h01C80000, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    do_reset_check();

    for (int i = 0; i < 150; i++) begin
      run_instr(gen_instr(), -1, 0, 1);
      if (ill_m || hlt_m) do_reset_check();
    end
    repeat (2) step(32'h0, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised successor to the CPU's instruction decoder. Adds an internal phase sequencer, so the phase is an output rather than an input.
- Decodes the byte-coded ALU/memory/branch subset once per instruction.
- Produces one-shot write strobes aligned to the memory and writeback phases.
- Detects illegal encodings, resolves the 0x89 ST/MOV ambiguity, and freezes the core on HLT or an illegal instruction.
- Sits between the instruction register and the ALU/regfile/memory/PC control.

Parameters:
- DATA_W, 32, datapath and `im` width; instruction word is fixed at 32 bits.
- IM_W, 8, width of the immediate field taken from ir[15:8]; legal range 1..8.
- RA_W, 3, width of the register address fields.
- BR_OFS, 3, instruction length added to the jump displacement.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ir  in  32  instruction register
- ir_valid  in  1  ir holds a fetched instruction
- stall  in  1  hold the current phase
- phase  out  5  one-hot phase: bit0 f, bit1 r, bit2 x, bit3 m, bit4 w
- op  out  4  ALU opcode, same 4-bit encoding as the existing ALU (ADD=0 … HLT=15)
- im  out  DATA_W  extended immediate
- use_im  out  1  ALU B operand is `im`
- br  out  2  branch kind: 10 = B, 01 = BCC, 00 = none
- ra1, ra2  out  RA_W  register addresses
- load_en  out  1  memory read
- wren_mem  out  1  memory write strobe
- wren_reg  out  1  regfile write strobe
- cr_taken  out  1  PC/branch commit strobe
- illegal  out  1  sticky illegal-instruction flag
- halted  out  1  sticky halt flag

Behaviour:
- Reset values:
  - phase = 00001
  - op = 0; im = 0; br = 0; ra1 = 0; ra2 = 0
  - use_im, load_en, wren_mem, wren_reg, cr_taken, illegal, halted all 0
- Phase ring f→r→x→m→w→f advances one step per clk.
  - Held when stall=1.
  - Held when halted=1 or illegal=1.
  - Held in f while ir_valid=0.
- Decode: at the clk edge ending an f cycle with ir_valid=1 and stall=0, decoded fields are registered.
  - ra1 = ir[21:19], ra2 = ir[18:16].
  - Fields stay stable until the next decode.
- Opcode map (ir[31:24]):
  - 8B: LD, load_en=1, reg write.
  - 89: if ir[23:22]=11 then MOV with reg write, else ST with mem write.
  - 66: LIL, use_im=1, reg write.
  - 01: ADD. 29: SUB. 39: CMP. 21: AND. 09: OR. 31: XOR. All with reg write.
  - 83: immediate ALU op, use_im=1, reg write, selected by ir[23:19]:
    - 11000 ADD, 11101 SUB, 11111 CMP, 11100 AND, 11001 OR, 11110 XOR.
  - F7: selected by ir[23:19]: 11011 NEG, 11010 NOT; reg write.
  - C1: shift, use_im=1, reg write, selected by ir[23:19]: 11100 SLL, 11101 SRL, 11111 SRA.
  - 90: jump.
    - op=ADD, use_im=1, cr_taken path enabled.
    - im = ext(ir[15:8]) + BR_OFS, modulo 2^DATA_W.
    - br selected by ir[23:20]: 1110 → B, 0111 → BCC.
  - F4: HLT.
- Immediate extension:
  - im = zero-extension of ir[8+IM_W-1:8] to DATA_W; 0 for non-immediate ops.
  - Extension is applied before the jump offset add.
- Illegal instructions:
  - Triggers: any opcode not listed, any unlisted sub-field under 83, F7, C1 or 90.
  - On decode: illegal is set, all strobes are suppressed, and the ring stops at r.
- HLT: on decode, halted is set and the ring stops at r.
- Strobes: each pulses for exactly one cycle per instruction.
  - wren_mem: first cycle in m.
  - wren_reg: first cycle in w.
  - cr_taken: first cycle in w.
  - A stall in m or w does not re-assert a strobe.
- Reset mid-instruction: returns to f immediately and clears all state; no strobe fires.
- stall and ir_valid=0 together in f: stall wins; the ring is held either way.

Optional Feature:
- Macro: DECODER_SEQ_IMM_SIGN_EXT_EN.
- When defined: the immediate field is sign-extended from bit 8+IM_W-1 to DATA_W, including for the jump displacement (backward jumps).
- When undefined: zero-extension, as stated above.

Decomposition:
- Package decoder_pkg holds:
  - op codes ADD..HLT (4-bit)
  - phase bit indices F, R, X, M, W
  - br codes B and BCC
  - opcode-byte constants
- Sub-module phase_ring: one-hot sequencer with stall, freeze and wait-in-f inputs, plus first-cycle-of-phase outputs used for strobe generation.

Test Plan:
- ir=0x01_C8_0000 (ADD, ra1=1, ra2=0), ir_valid=1, no stall → ra1=1, ra2=0, op=0, use_im=0; wren_reg high exactly in the w cycle (cycle 5 after f); wren_mem never high.
- ir=0x89_08_0000 (mod≠11) → op=ST, wren_mem one pulse in m, wren_reg 0. Then ir=0x89_C8_0000 → op=MOV, wren_reg pulse in w.
- ir=0x90_E0_FE00 → br=10, op=ADD, im=0x101 (0xFE+3) with the macro undefined, im=0x00000001 with it defined; cr_taken pulses in w.
- stall=1 held for 3 cycles in m during ST → phase stays 01000 for 4 cycles; wren_mem high only in the first of them.
- ir=0xFF_000000 → illegal=1, phase frozen at 00010, no strobes, until rst=1; rst pulse mid-x returns all outputs to reset values asynchronously.
- ir=0x83_F8_0500 (sub-field 11111, CMP imm) → op=2, use_im=1, im=5. Then ir=0xF4_000000 → halted=1 and the ring stops.
